// File: rtl/riscv_defines.sv
// Shared types and sizing for the branch predictor update path.
package riscv_defines;

  localparam int BP_ENTRIES = 64;
  localparam int IDX_W      = $clog2(BP_ENTRIES);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } bp_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_upd_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO of resolved branch updates with a single-cycle clear.
module bp_update_fifo
  import riscv_defines::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  logic    clr,
  input  bp_upd_t din,
  output bp_upd_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  bp_upd_t        r_mem [DEPTH];
  logic    [AW:0] r_wr_ptr;
  logic    [AW:0] r_rd_ptr;
  logic           w_do_push;
  logic           w_do_pop;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty && !clr;
  assign w_do_push = push && !clr && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// Owns the BHT/BTB write port: sweeps the tables after reset or flush, then
// drains buffered M-stage resolutions one per cycle.
module bp_update_ctrl
  import riscv_defines::*;
#(
  parameter int ENTRIES    = BP_ENTRIES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cflow_valid,
  input  logic [31:0]                pc_m,
  input  logic                       cflow_taken,
  input  logic [31:0]                cflow_target,
  input  logic                       flush_req,
  output logic                       tbl_we,
  output logic                       tbl_clr,
  output logic [$clog2(ENTRIES)-1:0] tbl_idx,
  output logic [31:0]                tbl_pc,
  output logic                       tbl_taken,
  output logic [31:0]                tbl_target,
  output logic                       pred_en,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);

  localparam int IW = $clog2(ENTRIES);

  bp_state_t         r_state;
  logic     [IW-1:0] r_sweep_idx;
  logic              w_sweeping;
  logic              w_sweep_last;
  logic              w_flush_acc;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  bp_upd_t           w_fifo_din;
  bp_upd_t           w_fifo_dout;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // A flush arriving mid-sweep is dropped: the sweep already clears everything.
  assign w_sweeping   = (r_state != RUN);
  assign w_sweep_last = &r_sweep_idx;
  assign w_flush_acc  = flush_req && (r_state == RUN);
  assign w_push       = cflow_valid && !w_flush_acc;
  assign w_pop        = (r_state == RUN) && !w_fifo_empty && !w_flush_acc;
  assign w_drop       = w_push && w_fifo_full && !w_pop;
  assign w_fifo_din   = {pc_m, cflow_taken, cflow_target};

  bp_update_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .pop  (w_pop),
    .clr  (w_flush_acc),
    .din  (w_fifo_din),
    .dout (w_fifo_dout),
    .full (w_fifo_full),
    .empty(w_fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CLEAR;
      r_sweep_idx <= '0;
      tbl_we      <= 1'b0;
      tbl_clr     <= 1'b0;
      tbl_idx     <= '0;
      tbl_pc      <= '0;
      tbl_taken   <= 1'b0;
      tbl_target  <= '0;
      pred_en     <= 1'b0;
      busy        <= 1'b1;
      drop_cnt    <= '0;
    end else begin
      case (r_state)
        CLEAR, FLUSH: begin
          r_sweep_idx <= r_sweep_idx + 1'b1;
          if (w_sweep_last) r_state <= RUN;
        end
        RUN: begin
          if (w_flush_acc) begin
            r_state     <= FLUSH;
            r_sweep_idx <= '0;
          end
        end
        default: begin
          r_state     <= CLEAR;
          r_sweep_idx <= '0;
        end
      endcase

      tbl_we  <= w_sweeping || w_pop;
      tbl_clr <= w_sweeping;
      if (w_sweeping) begin
        tbl_idx <= r_sweep_idx;
      end else if (w_pop) begin
        tbl_idx <= w_fifo_dout.pc[IW+1:2];
      end
      // Data fields only move on real updates; clear writes ignore them.
      if (w_pop) begin
        tbl_pc     <= w_fifo_dout.pc;
        tbl_taken  <= w_fifo_dout.taken;
        tbl_target <= w_fifo_dout.target;
      end

      pred_en <= !w_sweeping && !w_flush_acc;
      busy    <= w_sweeping || w_flush_acc;
      if (w_drop) drop_cnt <= sat_inc16(drop_cnt);
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_bp_update_ctrl;

  localparam int ENTRIES = 64;
  localparam int DEPTH   = 4;
  localparam int IW      = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cflow_valid = 1'b0;
  logic [31:0]   pc_m = '0;
  logic          cflow_taken = 1'b0;
  logic [31:0]   cflow_target = '0;
  logic          flush_req = 1'b0;
  logic          tbl_we;
  logic          tbl_clr;
  logic [IW-1:0] tbl_idx;
  logic [31:0]   tbl_pc;
  logic          tbl_taken;
  logic [31:0]   tbl_target;
  logic          pred_en;
  logic          busy;
  logic [15:0]   drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  bp_update_ctrl #(
    .ENTRIES   (ENTRIES),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cflow_valid (cflow_valid),
    .pc_m        (pc_m),
    .cflow_taken (cflow_taken),
    .cflow_target(cflow_target),
    .flush_req   (flush_req),
    .tbl_we      (tbl_we),
    .tbl_clr     (tbl_clr),
    .tbl_idx     (tbl_idx),
    .tbl_pc      (tbl_pc),
    .tbl_taken   (tbl_taken),
    .tbl_target  (tbl_target),
    .pred_en     (pred_en),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: sweep position, pending-update queue, expected outputs.
  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tg;
  } upd_t;

  upd_t          q[$];
  bit            m_sweep;
  int            m_pos;
  logic          e_we, e_clr, e_pred, e_tk;
  logic [IW-1:0] e_idx;
  logic [31:0]   e_pc, e_tg;
  logic [15:0]   e_drop;

  localparam logic [90:0] RESET_VEC = 91'd0;

  task automatic model_reset();
    q.delete();
    m_sweep = 1'b1;
    m_pos   = 0;
    e_we = 0; e_clr = 0; e_pred = 0; e_tk = 0;
    e_idx = '0; e_pc = '0; e_tg = '0; e_drop = '0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] pc, input bit tk,
                            input logic [31:0] tg, input bit fl);
    bit   was_sweep, acc;
    upd_t it;
    was_sweep = m_sweep;
    acc       = fl && !m_sweep;
    e_we  = 1'b0;
    e_clr = 1'b0;
    if (m_sweep) begin
      e_we  = 1'b1;
      e_clr = 1'b1;
      e_idx = m_pos[IW-1:0];
      m_pos++;
      if (m_pos == ENTRIES) m_sweep = 1'b0;
    end else if (acc) begin
      q.delete();
      m_sweep = 1'b1;
      m_pos   = 0;
    end else if (q.size() != 0) begin
      it    = q.pop_front();
      e_we  = 1'b1;
      e_idx = it.pc[IW+1:2];
      e_pc  = it.pc;
      e_tk  = it.tk;
      e_tg  = it.tg;
    end
    if (v && !acc) begin
      if (q.size() < DEPTH) q.push_back('{pc, tk, tg});
      else if (e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
    end
    e_pred = !was_sweep && !acc;
  endtask

  function automatic logic [90:0] obs();
    return {tbl_we, tbl_clr, tbl_idx, pred_en, busy, drop_cnt,
            (e_we && !e_clr) ? {tbl_pc, tbl_taken, tbl_target} : 65'd0};
  endfunction

  function automatic logic [90:0] expv();
    return {e_we, e_clr, e_idx, e_pred, !e_pred, e_drop,
            (e_we && !e_clr) ? {e_pc, e_tk, e_tg} : 65'd0};
  endfunction

  function automatic logic [90:0] rst_obs();
    return {tbl_we, tbl_clr, tbl_idx, pred_en, !busy, drop_cnt, tbl_pc, tbl_taken, tbl_target};
  endfunction

  task automatic step(input bit v, input logic [31:0] pc, input bit tk,
                      input logic [31:0] tg, input bit fl);
    cflow_valid  = v;
    pc_m         = pc;
    cflow_taken  = tk;
    cflow_target = tg;
    flush_req    = fl;
    @(posedge clk);
    model_edge(v, pc, tk, tg, fl);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cflow_valid = 0; flush_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (rst_obs() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", rst_obs(), RESET_VEC);
    end
  endtask

  task automatic test_reset_sweep();
    int n_clr, first_pred;
    n_clr = 0; first_pred = 0;
    for (int i = 1; i <= 66; i++) begin
      step(0, '0, 0, '0, 0);
      if (tbl_we && tbl_clr) n_clr++;
      if (pred_en && first_pred == 0) first_pred = i;
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL reset_sweep cyc %0d: got %h expected %h", i, obs(), expv());
      end
    end
    n_chk++;
    if (n_clr !== 64 || first_pred !== 65) begin
      n_fail++;
      $display("FAIL reset_sweep_profile: clears %0d pred_en at %0d, expected 64 and 65", n_clr, first_pred);
    end
  endtask

  task automatic test_single_update();
    step(1, 32'h0000_0104, 1, 32'h0000_0200, 0);
    step(0, '0, 0, '0, 0);
    n_chk++;
    if ({tbl_we, tbl_clr, tbl_idx, tbl_pc, tbl_taken, tbl_target} !==
        {1'b1, 1'b0, 6'h01, 32'h0000_0104, 1'b1, 32'h0000_0200}) begin
      n_fail++;
      $display("FAIL single_update: got we=%b clr=%b idx=%h pc=%h tk=%b tg=%h expected 1 0 01 00000104 1 00000200",
               tbl_we, tbl_clr, tbl_idx, tbl_pc, tbl_taken, tbl_target);
    end
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL single_update_model: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_back_to_back();
    int n_upd;
    n_upd = 0;
    for (int i = 0; i < 9; i++) begin
      step(i < 8, $urandom, 1'($urandom), $urandom, 0);
      if (i > 0 && tbl_we && !tbl_clr) n_upd++;
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", i, obs(), expv());
      end
    end
    n_chk++;
    if (n_upd !== 8) begin
      n_fail++;
      $display("FAIL back_to_back_rate: got %0d updates expected 8", n_upd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), $urandom, 1'($urandom), $urandom, ($urandom_range(0, 63) == 0));
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", i, obs(), expv());
      end
    end
    for (int i = 0; i < 70; i++) step(0, '0, 0, '0, 0);
  endtask

  task automatic test_overflow();
    logic [31:0] pcs [6];
    do_reset();
    for (int i = 0; i < 6; i++) pcs[i] = 32'h0000_1000 + 32'(i * 4);
    for (int i = 1; i <= 64; i++) begin
      if (i <= 6) step(1, pcs[i-1], 1'(i), ~pcs[i-1], 0);
      else step(0, '0, 0, '0, 0);
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL overflow cyc %0d: got %h expected %h", i, obs(), expv());
      end
    end
    n_chk++;
    if (drop_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL overflow_drop_cnt: got %0d expected 2", drop_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, '0, 0, '0, 0);
      n_chk++;
      if ({tbl_we, tbl_clr, tbl_pc, tbl_taken, tbl_target} !== {2'b10, pcs[k], 1'(k + 1), ~pcs[k]}) begin
        n_fail++;
        $display("FAIL overflow_drain %0d: got we=%b clr=%b pc=%h expected 1 0 %h", k, tbl_we, tbl_clr, tbl_pc, pcs[k]);
      end
    end
    step(0, '0, 0, '0, 0);
    n_chk++;
    if (tbl_we !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_tail: got we=%b expected 0", tbl_we);
    end
  endtask

  task automatic test_reset_mid_flush();
    int n_clr;
    step(0, '0, 0, '0, 1);
    n_chk++;
    if ({pred_en, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_pred_fall: got pred_en=%b busy=%b expected 0 1", pred_en, busy);
    end
    for (int i = 0; i <= 10; i++) step(0, '0, 0, '0, 0);
    n_chk++;
    if ({tbl_we, tbl_clr, tbl_idx} !== {2'b11, 6'd10}) begin
      n_fail++;
      $display("FAIL mid_flush_idx: got we=%b clr=%b idx=%0d expected 1 1 10", tbl_we, tbl_clr, tbl_idx);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (rst_obs() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_mid_flush: got %h expected %h", rst_obs(), RESET_VEC);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_clr = 0;
    for (int i = 1; i <= 66; i++) begin
      step(0, '0, 0, '0, 0);
      if (tbl_we && tbl_clr) n_clr++;
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL post_reset_sweep cyc %0d: got %h expected %h", i, obs(), expv());
      end
    end
    n_chk++;
    if (n_clr !== 64) begin
      n_fail++;
      $display("FAIL post_reset_sweep_count: got %0d expected 64", n_clr);
    end
  endtask

  task automatic test_flush_pending();
    int n_upd, n_clr;
    do_reset();
    for (int i = 1; i <= 64; i++) step(i <= 3, 32'h0000_2000 + 32'(i * 4), 1, 32'h0000_3000, 0);
    step(1, 32'h0000_4000, 1, 32'h0000_5000, 1);
    n_upd = (tbl_we && !tbl_clr) ? 1 : 0;
    n_clr = 0;
    for (int i = 0; i < 66; i++) begin
      step(0, '0, 0, '0, 0);
      if (tbl_we && !tbl_clr) n_upd++;
      if (tbl_we && tbl_clr) n_clr++;
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL flush_pending cyc %0d: got %h expected %h", i, obs(), expv());
      end
    end
    n_chk++;
    if (n_upd !== 0 || n_clr !== 64 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL flush_pending_summary: updates %0d clears %0d drops %0d expected 0 64 0", n_upd, n_clr, drop_cnt);
    end
  endtask

  task automatic test_flush_during_sweep();
    int n_clr, first_pred;
    do_reset();
    n_clr = 0; first_pred = 0;
    for (int i = 1; i <= 66; i++) begin
      step(0, '0, 0, '0, i == 31);
      if (tbl_we && tbl_clr) n_clr++;
      if (pred_en && first_pred == 0) first_pred = i;
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL flush_in_sweep cyc %0d: got %h expected %h", i, obs(), expv());
      end
    end
    n_chk++;
    if (n_clr !== 64 || first_pred !== 65) begin
      n_fail++;
      $display("FAIL flush_in_sweep_profile: clears %0d pred_en at %0d, expected 64 and 65", n_clr, first_pred);
    end
  endtask

  initial begin
    test_reset();
    test_reset_sweep();
    test_single_update();
    test_back_to_back();
    test_random();
    test_overflow();
    test_reset_mid_flush();
    test_flush_pending();
    test_flush_during_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
